// File: rtl/eth_rx_axis_frame_fifo.sv
// eth_rx_axis_frame_fifo: store-and-forward frame FIFO behind the 10G RX MAC, AXI-Stream master out
//   Frames are written speculatively and only become visible to the read side once their
//   last beat arrives clean; errored or overflowing frames are rolled back.
//   Ports:
//     i_rx_clk, i_rx_reset_n          clock, asynchronous active-low reset
//     s_data/_keep/_valid/_last/_err  RX MAC beat input, no backpressure
//     m_axis_tdata/_tkeep/_tvalid/_tlast, m_axis_trdy   AXI-Stream master
//     o_overflow                      one-cycle pulse per frame dropped for lack of space
//   Optional: define RX_FIFO_STATUS_CNT_EN to add saturating o_good_frames,
//   o_err_frames and o_ovf_frames.
module eth_rx_axis_frame_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [CTRL_WIDTH-1:0] s_data_keep,
  input  logic                  s_data_valid,
  input  logic                  s_data_last,
  input  logic                  s_data_err,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,
  output logic                  o_overflow
`ifdef RX_FIFO_STATUS_CNT_EN
  ,
  output logic [31:0]           o_good_frames,
  output logic [31:0]           o_err_frames,
  output logic [31:0]           o_ovf_frames
`endif
);
  localparam int W = DATA_WIDTH + CTRL_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  typedef enum logic {ACCEPT, DROP} wr_state_t;
  wr_state_t state, state_nxt;
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr, wr_ptr_nxt, wr_commit_nxt;
  logic err_q, err_nxt, err_any, full, accept, wr_en, ovf_nxt, commit, rollback;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] ram_q, e0, e1;
  logic rd_en, rd_valid_q, avail, pop, push;
  logic [1:0] cnt, cnt_after_pop, cnt_nxt;
  assign full = (wr_ptr - rd_ptr) == FULL_CNT;
  assign err_any = err_q | s_data_err;
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n)
    if (!i_rx_reset_n) state <= ACCEPT;
    else state <= state_nxt;
  always_comb
    state_nxt = !s_data_valid ? state
              : (state == DROP) ? (s_data_last ? ACCEPT : DROP)
              : (full && !s_data_last) ? DROP : ACCEPT;
  // Overflow and error both roll the speculative pointer back to the last committed frame.
  always_comb begin
    accept = s_data_valid && state == ACCEPT;
    wr_en = accept && !full;
    ovf_nxt = accept && full;
    commit = wr_en && s_data_last && !err_any;
    rollback = wr_en && s_data_last && err_any;
    wr_ptr_nxt = (ovf_nxt || rollback) ? wr_commit : wr_en ? wr_ptr + PTR_ONE : wr_ptr;
    wr_commit_nxt = commit ? wr_ptr + PTR_ONE : wr_commit;
    err_nxt = !s_data_valid ? err_q : (wr_en && !s_data_last) ? err_any : 1'b0;
  end
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n)
    if (!i_rx_reset_n) begin
      wr_ptr <= '0;
      wr_commit <= '0;
      err_q <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
      err_q <= err_nxt;
      o_overflow <= ovf_nxt;
    end
  always_ff @(posedge i_rx_clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_data_last, s_data_keep, s_data};
    if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end
  // Read side: a RAM read is issued only if the skid entries plus the read in flight
  // still fit in two slots after this cycle's pop, so nothing is ever lost.
  assign avail = wr_commit != rd_ptr;
  assign m_axis_tvalid = cnt != 2'd0;
  assign pop = m_axis_tvalid && m_axis_trdy;
  assign push = rd_valid_q;
  assign cnt_after_pop = cnt - {1'b0, pop};
  assign rd_en = avail && (cnt_after_pop + {1'b0, rd_valid_q}) < 2'd2;
  assign cnt_nxt = cnt_after_pop + {1'b0, push};
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n)
    if (!i_rx_reset_n) begin
      rd_ptr <= '0;
      rd_valid_q <= 1'b0;
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      rd_ptr <= rd_en ? rd_ptr + PTR_ONE : rd_ptr;
      rd_valid_q <= rd_en;
      cnt <= cnt_nxt;
      e0 <= (push && cnt_after_pop == 2'd0) ? ram_q : (pop && cnt == 2'd2) ? e1 : e0;
      e1 <= (push && cnt_after_pop == 2'd1) ? ram_q : e1;
    end
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = e0;
`ifdef RX_FIFO_STATUS_CNT_EN
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n)
    if (!i_rx_reset_n) begin
      o_good_frames <= '0;
      o_err_frames <= '0;
      o_ovf_frames <= '0;
    end else begin
      o_good_frames <= (commit && o_good_frames != '1) ? o_good_frames + 32'd1 : o_good_frames;
      o_err_frames <= (rollback && o_err_frames != '1) ? o_err_frames + 32'd1 : o_err_frames;
      o_ovf_frames <= (ovf_nxt && o_ovf_frames != '1) ? o_ovf_frames + 32'd1 : o_ovf_frames;
    end
`endif
endmodule

// File: tb/tb_eth_rx_axis_frame_fifo.sv
// tb_eth_rx_axis_frame_fifo: random and directed frames checked against a queue model of committed beats
module tb_eth_rx_axis_frame_fifo;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int W = DW + CW + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_data_keep;
  logic s_data_valid, s_data_last, s_data_err;
  logic [DW-1:0] m_axis_tdata;
  logic [CW-1:0] m_axis_tkeep;
  logic m_axis_tvalid, m_axis_tlast, m_axis_trdy, o_overflow;
`ifdef RX_FIFO_STATUS_CNT_EN
  logic [31:0] good_frames, err_frames, ovf_frames;
`endif
  eth_rx_axis_frame_fifo #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .i_rx_clk(clk),
    .i_rx_reset_n(rst_n),
    .s_data(s_data),
    .s_data_keep(s_data_keep),
    .s_data_valid(s_data_valid),
    .s_data_last(s_data_last),
    .s_data_err(s_data_err),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_trdy(m_axis_trdy),
    .o_overflow(o_overflow)
`ifdef RX_FIFO_STATUS_CNT_EN
    ,
    .o_good_frames(good_frames),
    .o_err_frames(err_frames),
    .o_ovf_frames(ovf_frames)
`endif
  );
  always #5 clk = ~clk;
  logic [W-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int out_beats = 0, n_last = 0, ovf_seen = 0, exp_ovf = 0, exp_good = 0, exp_err = 0;
  int rdy_mode = 0;
  logic [CW-1:0] last_keep_seen = '0;
  bit prev_stall = 0;
  logic [W:0] held;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_trdy = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
  end
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, held);
      if (m_axis_tvalid) begin
        check("tvalid_only_when_committed", exp_q.size() != 0, 1);
        if (m_axis_trdy && exp_q.size() != 0) begin
          check("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
          out_beats++;
          if (m_axis_tlast) begin
            n_last++;
            last_keep_seen = m_axis_tkeep;
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_trdy;
      held = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (o_overflow) ovf_seen++;
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic idle();
    s_data_valid = 0;
    s_data_last = 0;
    s_data_err = 0;
  endtask
  task automatic send_frame(input int len, input int err_beat, input logic [CW-1:0] lkeep, input bit good);
    logic [W-1:0] fq[$];
    logic [DW-1:0] d;
    logic [CW-1:0] k;
    logic l;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      l = (i == len - 1);
      k = l ? lkeep : '1;
      s_data = d;
      s_data_keep = k;
      s_data_last = l;
      s_data_err = (i == err_beat);
      s_data_valid = 1;
      fq.push_back({l, k, d});
      cyc(1);
    end
    if (good) begin
      foreach (fq[i]) exp_q.push_back(fq[i]);
      exp_good++;
    end
  endtask
  task automatic drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < budget) begin
      cyc(1);
      c++;
    end
    if (c >= budget) check("drain_timeout", exp_q.size(), 0);
  endtask
  initial begin
    int b0, l0, o0, len, eb, g;
    bit lat_ok;
    logic [CW-1:0] lk;
    s_data = '0;
    s_data_keep = '0;
    m_axis_trdy = 0;
    idle();
    cyc(3);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_overflow", o_overflow, 0);
    rst_n = 1;
    cyc(1);
    rdy_mode = 1;
    cyc(2);
    b0 = out_beats;
    l0 = n_last;
    send_frame(16, -1, 4'h3, 1);
    idle();
    lat_ok = 0;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      if (m_axis_tvalid) lat_ok = 1;
    end
    check("first_tvalid_latency", lat_ok, 1);
    drain(200);
    check("t1_beats", out_beats - b0, 16);
    check("t1_tlast_count", n_last - l0, 1);
    check("t1_last_keep", last_keep_seen, 4'h3);
    b0 = out_beats;
    l0 = n_last;
    send_frame(16, 15, 4'hF, 0);
    exp_err++;
    send_frame(8, -1, 4'hF, 1);
    idle();
    drain(200);
    check("t2_beats", out_beats - b0, 8);
    check("t2_tlast_count", n_last - l0, 1);
    rdy_mode = 0;
    cyc(2);
    o0 = ovf_seen;
    send_frame(DEPTH + 8, -1, 4'hF, 0);
    exp_ovf++;
    send_frame(10, -1, 4'hF, 1);
    idle();
    cyc(5);
    check("t3_overflow_pulses", ovf_seen - o0, 1);
    check("t3_tvalid_stalled", m_axis_tvalid, 1);
    b0 = out_beats;
    rdy_mode = 1;
    drain(200);
    check("t3_beats", out_beats - b0, 10);
    rdy_mode = 0;
    cyc(2);
    send_frame(5, -1, 4'hF, 1);
    send_frame(6, -1, 4'h7, 1);
    for (int i = 0; i < 4; i++) begin
      s_data = $urandom;
      s_data_keep = '1;
      s_data_last = 0;
      s_data_err = 0;
      s_data_valid = 1;
      cyc(1);
    end
    s_data = $urandom;
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_tkeep", m_axis_tkeep, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_overflow", o_overflow, 0);
    exp_q.delete();
    exp_good = 0;
    exp_err = 0;
    exp_ovf = 0;
    ovf_seen = 0;
    idle();
    cyc(2);
    #2;
    rst_n = 1;
    cyc(1);
    rdy_mode = 1;
    b0 = out_beats;
    send_frame(4, -1, 4'h1, 1);
    idle();
    drain(100);
    check("post_rst_beats", out_beats - b0, 4);
    rdy_mode = 0;
    cyc(2);
    send_frame(DEPTH / 2, -1, 4'hF, 1);
    send_frame(DEPTH / 2, -1, 4'h3, 1);
    idle();
    cyc(4);
    o0 = ovf_seen;
    b0 = out_beats;
    check("fill_tvalid", m_axis_tvalid, 1);
    rdy_mode = 1;
    send_frame(1, -1, 4'h7, 1);
    rdy_mode = 0;
    idle();
    cyc(3);
    rdy_mode = 1;
    drain(2000);
    check("fill_no_overflow", ovf_seen - o0, 0);
    check("fill_beats", out_beats - b0, DEPTH + 1);
    rdy_mode = 2;
    for (int f = 0; f < 80; f++) begin
      len = $urandom_range(16, 380);
      eb = ($urandom % 4 == 0) ? int'($urandom_range(0, len - 1)) : -1;
      lk = 4'hF >> ($urandom % 4);
      g = 0;
      if (exp_q.size() + len > DEPTH) idle();
      while (exp_q.size() + len > DEPTH && g < 4000) begin
        cyc(1);
        g++;
      end
      if (g >= 4000) check("space_wait_timeout", exp_q.size() + len <= DEPTH, 1);
      send_frame(len, eb, lk, eb < 0);
      if (eb >= 0) exp_err++;
      if ($urandom % 3 == 0) begin
        idle();
        cyc($urandom_range(1, 4));
      end
    end
    idle();
    drain(5000);
    check("total_overflow_pulses", ovf_seen, exp_ovf);
`ifdef RX_FIFO_STATUS_CNT_EN
    check("good_frames", good_frames, exp_good);
    check("err_frames", err_frames, exp_err);
    check("ovf_frames", ovf_frames, exp_ovf);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
